sw_capture_bank: RTL and testbench
==================================

# sw_capture_bank

Parametrised switch-capture register bank for the DE2 board top level: samples `SW` into one of `DEPTH` slots on a debounced `KEY[0]` press, lets the user step through slots with `KEY[1]`, clears with `KEY[2]`, and drives the selected slot and its index to 7-segment displays. It replaces single-register capture clocked directly by a key. Everything runs synchronously on `CLOCK_50`, and keys are synchronised and debounced.

## Interface
- `DATA_W`, default 3: bits captured per slot, taken from `SW[DATA_W-1:0]`; legal range 1..4.
- `DEPTH`, default 4: number of slots; legal range 2..16.
- `DEBOUNCE_CYCLES`, default 1000000: stable cycles required to accept a key level; minimum 2.
- `CLOCK_50` in, 1: single clock; all state changes on its rising edge.
- `RESET_N` in, 1: asynchronous, active-low reset.
- `SW` in, 18: switches; asynchronous, quasi-static.
- `KEY` in, 4: pushbuttons, active-low (1 = released). `KEY[0]` capture, `KEY[1]` next slot, `KEY[2]` clear. `KEY[3]` unused.
- `HEX0` out, [0:6]: active-low segments a..g showing the selected slot value.
- `HEX1` out, [0:6]: active-low segments showing the selected slot index in hex.
- `LEDR` out, `DEPTH`: valid flag per slot.

## Operation
- **Key path, per key 0..2:**
  - 2-flop synchroniser feeds the debouncer.
  - Debouncer holds accepted level `db`, reset value 1, and a counter.
  - When the synchronised level differs from `db`, the counter increments. When it equals `db`, the counter clears.
  - When the counter reaches `DEBOUNCE_CYCLES-1` while still differing, `db` flips and the counter clears.
  - A press event is the `db` 1->0 flip and lasts one cycle. Release (0->1) generates no event.
- **Capture (`KEY[0]` event):**
  - `slot[wr_ptr] <= SW[DATA_W-1:0]`, `valid[wr_ptr] <= 1`, `wr_ptr <= (wr_ptr+1) mod DEPTH`.
  - When the bank is full, capture wraps and overwrites the oldest slot.
- **Next (`KEY[1]` event):** `rd_ptr <= (rd_ptr+1) mod DEPTH`.
- **Clear (`KEY[2]` event):** all `valid` <= 0, `wr_ptr` <= 0, `rd_ptr` <= 0. Slot data is left unchanged.
- **Simultaneous events:**
  - Clear overrides capture and next in the same cycle.
  - Capture and next in the same cycle both take effect. The display reflects the new `rd_ptr` and the slot write independently.
- **Display:**
  - `HEX0` decodes `{0, slot[rd_ptr]}` zero-extended to 4 bits as hex 0..F when `valid[rd_ptr]`. Otherwise it shows blank (7'b1111111).
  - `HEX1` always decodes `rd_ptr`.
  - Both displays are combinational from registers.
- **`LEDR[i]`** equals `valid[i]`.
- **Reset state:**
  - All slots 0, `valid` 0, both pointers 0, debouncer counters 0, synchronisers 1, `db` 1.
  - Outputs during reset: `HEX0` blank, `HEX1` shows "0", `LEDR` 0.
- **Reset asserted mid-debounce or mid-press:** state returns to the reset state immediately. A key still held after reset release generates one press once it is stable for `DEBOUNCE_CYCLES`.

## Timing
- Let edge 1 be the first rising edge sampling `KEY[n]`=0. The synchroniser output is low after edge 2.
- With debounce: `db` flips and the action register updates at edge `2+DEBOUNCE_CYCLES`. Outputs change in that same cycle.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles produces no event.
- Holding a key generates exactly one event. A new event requires release for `DEBOUNCE_CYCLES` cycles and then a new press.
- There are no stalls or handshakes. The block accepts one event per key per press.

## Configuration
- `SW_CAPTURE_DEBOUNCE_EN` defined: debouncer present as above.
- `SW_CAPTURE_DEBOUNCE_EN` not defined:
  - `db` equals the synchroniser output and `DEBOUNCE_CYCLES` is ignored.
  - The action occurs at edge 3 after edge 1.
  - Every synchronised 1->0 transition, including bounces, is an event.
  - This build is intended for fast simulation.

## Test plan
All scenarios use `DATA_W`=3, `DEPTH`=4, `DEBOUNCE_CYCLES`=4, with the macro defined.
- **Reset:** assert `RESET_N`=0 mid-run -> immediately `HEX0`=7'b1111111, `HEX1`="0" (7'b0000001), `LEDR`=4'b0000.
- **Single capture:** `SW[2:0]`=5, `KEY[0]` low 10 cycles -> at edge 6 `LEDR`=0001 and `HEX0`="5" (7'b0100100). Holding the key produces no second write.
- **Glitch:** `KEY[0]` low 3 cycles then high -> no change to `LEDR` or slots.
- **Wrap-around:** capture values 1,2,3,4,6 -> slot0=6, `LEDR`=1111. `KEY[1]` pressed 4 times steps `HEX1` through 1,2,3,0 and `HEX0` through 2,3,4,6.
- **Simultaneous events:**
  - Clear pressed with capture -> `LEDR`=0000, pointers 0, `HEX0` blank.
  - Capture pressed with next -> write lands at old `wr_ptr`, `rd_ptr`+1.
- **Macro undefined:** `KEY[0]` low 1 cycle -> capture at edge 3. A bounce pattern 1-0-1-0 yields two captures.

Source files
------------

// File: rtl/sw_capture_bank.sv
// sw_capture_bank -- switch-capture register bank for the DE2 top level.
//
// Captures SW[DATA_W-1:0] into one of DEPTH slots on a KEY[0] press, steps
// the displayed slot with KEY[1], clears the bank with KEY[2]. The selected
// slot value goes to HEX0 (blank when the slot is empty) and its index to
// HEX1. Everything is synchronous to CLOCK_50; the keys are synchronised and
// debounced before they become one-cycle press events.
//
// Build option:
//   SW_CAPTURE_DEBOUNCE_EN  defined   -> per-key debouncer (DEBOUNCE_CYCLES)
//                           undefined -> synchronised level used directly;
//                                        every 1->0 edge is a press (sim use)
//
// Ports:
//   CLOCK_50      in   single clock, rising edge
//   RESET_N       in   asynchronous active-low reset
//   SW[17:0]      in   switches, only [DATA_W-1:0] are captured
//   KEY[3:0]      in   active-low buttons: 0 capture, 1 next, 2 clear, 3 unused
//   HEX0[0:6]     out  active-low segments a..g, selected slot value
//   HEX1[0:6]     out  active-low segments a..g, selected slot index
//   LEDR[DEPTH-1:0] out per-slot valid flags

// Per-key path: 2-flop synchroniser, optional debouncer, falling-edge press.
module sw_key_path #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
    $error("sw_key_path: DEBOUNCE_CYCLES must be at least 2");
  end

  // Released level (1) is the reset value so a held key after reset looks
  // like a fresh press once it has been stable long enough.
  logic [1:0] sync_q, sync_d;
  logic       key_s;

  assign sync_d = {sync_q[0], key_n};
  assign key_s  = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= sync_d;
  end

`ifdef SW_CAPTURE_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronised level disagrees with the
  // accepted level; any agreement restarts the qualification window.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (key_s != db_q) begin
      if (cnt_q == CNT_LAST) db_d  = key_s;
      else                   cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q  <= 1'b1;
      cnt_q <= '0;
    end else begin
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  // Press is taken from the flip itself so the action lands on the same
  // edge as the accepted level changes.
  assign press = db_q & ~db_d;
`else
  // db is the synchronised level; db_q only remembers it for edge detect.
  logic db_q, db_d;

  assign db_d = key_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) db_q <= 1'b1;
    else        db_q <= db_d;
  end

  assign press = db_q & ~key_s;
`endif

endmodule

module sw_capture_bank #(
  parameter int DATA_W          = 3,
  parameter int DEPTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic [17:0]      SW,
  input  logic [3:0]       KEY,
  output logic [0:6]       HEX0,
  output logic [0:6]       HEX1,
  output logic [DEPTH-1:0] LEDR
);

  if (DATA_W < 1 || DATA_W > 4) begin : g_bad_data_w
    $error("sw_capture_bank: DATA_W must be 1..4");
  end
  if (DEPTH < 2 || DEPTH > 16) begin : g_bad_depth
    $error("sw_capture_bank: DEPTH must be 2..16");
  end

  localparam int NUM_KEYS = 3;
  localparam int PW       = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  // ---------------------------------------------------------------- keys
  logic [NUM_KEYS-1:0] press;
  logic                cap_ev, nxt_ev, clr_ev;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    sw_key_path #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .clk   (CLOCK_50),
      .rst_n (RESET_N),
      .key_n (KEY[k]),
      .press (press[k])
    );
  end

  assign cap_ev = press[0];
  assign nxt_ev = press[1];
  assign clr_ev = press[2];

  // Upper switches and KEY[3] are not part of this block.
  logic unused_in;
  assign unused_in = ^{SW[17:DATA_W], KEY[3]};

  // ---------------------------------------------------------------- bank
  logic [DEPTH-1:0][DATA_W-1:0] slot_q, slot_d;
  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [PW-1:0]                wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]                rd_ptr_q, rd_ptr_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Clear wins outright. Capture and next are independent, so both may
  // fire together; a full bank simply wraps onto the oldest slot.
  always_comb begin
    slot_d   = slot_q;
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr_ev) begin
      valid_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (cap_ev) begin
        slot_d[wr_ptr_q]  = SW[DATA_W-1:0];
        valid_d[wr_ptr_q] = 1'b1;
        wr_ptr_d          = ptr_inc(wr_ptr_q);
      end
      if (nxt_ev) rd_ptr_d = ptr_inc(rd_ptr_q);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      slot_q   <= '0;
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      slot_q   <= slot_d;
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // ------------------------------------------------------------- display
  // Patterns are a..g, MSB first, active low.
  function automatic logic [0:6] seg7(input logic [3:0] v);
    logic [0:6] s;
    case (v)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  logic [DATA_W-1:0] rd_val;
  assign rd_val = slot_q[rd_ptr_q];

  always_comb begin
    HEX0 = 7'b1111111;
    if (valid_q[rd_ptr_q]) HEX0 = seg7(4'(rd_val));
    HEX1 = seg7(4'(rd_ptr_q));
  end

  assign LEDR = valid_q;

endmodule

// File: tb/tb_sw_capture_bank.sv
// Bench for sw_capture_bank (DATA_W=3, DEPTH=4, DEBOUNCE_CYCLES=4).
// Stimulus drives key levels per cycle on the falling clock edge and runs a
// behavioural model of the upcoming rising edge, pushing the expected display
// state into a queue; a monitor pops and compares after every rising edge.
// The model follows whichever build (debounced or not) the macro selects.
module tb_sw_capture_bank;

  localparam int DATA_W = 3;
  localparam int DEPTH  = 4;
  localparam int DBC    = 4;
`ifdef SW_CAPTURE_DEBOUNCE_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif

  logic             clk = 1'b1;
  logic             RESET_N;
  logic [17:0]      SW;
  logic [3:0]       KEY;
  logic [0:6]       HEX0, HEX1;
  logic [DEPTH-1:0] LEDR;

  always #5 clk = ~clk;

  sw_capture_bank #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .DEBOUNCE_CYCLES(DBC)
  ) dut (
    .CLOCK_50(clk), .RESET_N(RESET_N), .SW(SW), .KEY(KEY),
    .HEX0(HEX0), .HEX1(HEX1), .LEDR(LEDR)
  );

  typedef struct packed {
    logic [6:0]       h0;
    logic [6:0]       h1;
    logic [DEPTH-1:0] led;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc_n = 0;

  // a..g active-low digit shapes
  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  // ------------------------------------------------------------- model
  // key_hist[k][0] = level seen at the last edge, [1] = the edge before;
  // the level a key action sees is the one from two edges back.
  bit key_hist [3][2];
  bit acc_lvl  [3];   // accepted key level (or last seen level, no debounce)
  int diff_run [3];   // consecutive edges the seen level disagreed
  int m_slot   [DEPTH];
  bit m_val    [DEPTH];
  int m_wr, m_rd;

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      key_hist[k][0] = 1'b1;
      key_hist[k][1] = 1'b1;
      acc_lvl[k]     = 1'b1;
      diff_run[k]    = 0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      m_slot[i] = 0;
      m_val[i]  = 1'b0;
    end
    m_wr = 0;
    m_rd = 0;
  endfunction

  function automatic void model_edge(input logic [3:0] key, input logic [17:0] sw);
    bit ev [3];
    bit seen;
    for (int k = 0; k < 3; k++) begin
      seen           = key_hist[k][1];
      key_hist[k][1] = key_hist[k][0];
      key_hist[k][0] = key[k];
      ev[k]          = 1'b0;
      if (DB_EN) begin
        // accept a new level after DBC consecutive disagreeing edges
        if (seen != acc_lvl[k]) begin
          diff_run[k]++;
          if (diff_run[k] == DBC) begin
            acc_lvl[k]  = seen;
            diff_run[k] = 0;
            ev[k]       = !seen;
          end
        end else begin
          diff_run[k] = 0;
        end
      end else begin
        ev[k]      = acc_lvl[k] && !seen;
        acc_lvl[k] = seen;
      end
    end
    if (ev[2]) begin
      for (int i = 0; i < DEPTH; i++) m_val[i] = 1'b0;
      m_wr = 0;
      m_rd = 0;
    end else begin
      if (ev[0]) begin
        m_slot[m_wr] = int'(sw) % (1 << DATA_W);
        m_val[m_wr]  = 1'b1;
        m_wr         = (m_wr + 1) % DEPTH;
      end
      if (ev[1]) m_rd = (m_rd + 1) % DEPTH;
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.h0 = m_val[m_rd] ? seg_tab[m_slot[m_rd]] : 7'b1111111;
    e.h1 = seg_tab[m_rd];
    for (int i = 0; i < DEPTH; i++) e.led[i] = m_val[i];
    return e;
  endfunction

  task automatic compare(input string name, input exp_t e);
    logic [6:0] a0, a1;
    a0 = HEX0;
    a1 = HEX1;
    total++;
    if (a0 !== e.h0 || a1 !== e.h1 || LEDR !== e.led) begin
      bad++;
      $display("FAIL %s cyc=%0d got HEX0=%b HEX1=%b LEDR=%b want HEX0=%b HEX1=%b LEDR=%b",
               name, cyc_n, a0, a1, LEDR, e.h0, e.h1, e.led);
    end
  endtask

  // --------------------------------------------------------- stimulus
  task automatic cyc(input logic [3:0] key, input logic [17:0] sw, input logic rst_n);
    logic was_rst_n;
    @(negedge clk);
    cyc_n++;
    was_rst_n = RESET_N;
    KEY       = key;
    SW        = sw;
    RESET_N   = rst_n;
    if (!rst_n) begin
      model_reset();
      // reset is asynchronous: outputs must already be in reset state
      if (was_rst_n) begin
        #1;
        compare("reset_now", model_out());
      end
    end else begin
      model_edge(key, sw);
    end
    exp_q.push_back(model_out());
  endtask

  task automatic press(input logic [2:0] mask, input logic [17:0] sw,
                       input int hold, input int rel);
    for (int i = 0; i < hold; i++) cyc({1'b1, ~mask}, sw, 1'b1);
    for (int i = 0; i < rel; i++)  cyc(4'hF, sw, 1'b1);
  endtask

  // ---------------------------------------------------------- monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        compare("outputs", e);
      end
    end
  end

  initial begin
    int wrap_vals [5] = '{1, 2, 3, 4, 6};
    RESET_N = 1'b0;
    KEY     = 4'hF;
    SW      = '0;
    model_reset();

    repeat (3) cyc(4'hF, 18'd0, 1'b0);
    repeat (3) cyc(4'hF, 18'd0, 1'b1);

    // single capture of 5, key held well past the debounce window
    press(3'b001, 18'd5, 10, DBC + 3);
    // short glitch
    press(3'b001, 18'd7, DBC - 1, DBC + 3);

    // mid-run reset, then wrap-around fill
    repeat (2) cyc(4'hF, 18'd0, 1'b0);
    repeat (2) cyc(4'hF, 18'd0, 1'b1);
    foreach (wrap_vals[i]) press(3'b001, 18'(wrap_vals[i]), DBC + 2, DBC + 2);
    repeat (4) press(3'b010, 18'd0, DBC + 2, DBC + 2);

    // clear together with capture, then capture together with next
    press(3'b101, 18'd3, DBC + 2, DBC + 2);
    press(3'b001, 18'd2, DBC + 2, DBC + 2);
    press(3'b011, 18'd7, DBC + 2, DBC + 2);

    // one-cycle pulses and a 1-0-1-0 bounce
    press(3'b001, 18'd5, 1, 1);
    press(3'b001, 18'd6, 1, 1);
    press(3'b001, 18'd6, 1, DBC + 3);

    // reset in the middle of a held press; the held key presses once after
    repeat (3) cyc(4'b1110, 18'd4, 1'b1);
    repeat (2) cyc(4'b1110, 18'd4, 1'b0);
    repeat (DBC + 4) cyc(4'b1110, 18'd4, 1'b1);
    repeat (DBC + 3) cyc(4'hF, 18'd4, 1'b1);

    // randomized key combinations, lengths and occasional resets
    for (int it = 0; it < 250; it++) begin
      if ($urandom_range(0, 24) == 0)
        repeat ($urandom_range(1, 2)) cyc(4'hF, 18'($urandom), 1'b0);
      press(3'($urandom_range(1, 7)), 18'($urandom),
            $urandom_range(1, DBC + 3), $urandom_range(1, DBC + 3));
    end

    @(posedge clk);
    #4;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
